// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Feeds one nibble per slot to the shared decoder, with dead-time, leading-zero blanking and frame-aligned loads.
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int BLANK  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic                  load_ready,
    input  logic                  lz_en,
    output logic [4:0]            dig_code,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK  = CW'(BLANK);
    localparam logic [IW-1:0] IDX_MAX    = IW'(DIGITS - 1);
    localparam logic [4:0]    CODE_BLANK = 5'h1F;

    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [4*DIGITS-1:0]   shadow, shadow_nxt;
    logic [4*DIGITS-1:0]   pending;
    logic                  pending_full;
    logic                  wrap, boundary, accept;
    logic                  upper_zero, lz_blank, show;
    logic [3:0]            nib;
    logic [DIGITS-1:0]     an_n_nxt;
    logic [4:0]            dig_code_nxt;

    assign load_ready = ~pending_full;

    // Counter advance and frame-boundary shadow update.
    always_comb begin
        wrap       = (cnt == CNT_MAX);
        boundary   = wrap && (idx == IDX_MAX);
        accept     = load_valid && !pending_full;
        cnt_nxt    = wrap ? '0 : cnt + 1'b1;
        idx_nxt    = idx;
        if (wrap) begin
            idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
        shadow_nxt = (boundary && pending_full) ? pending : shadow;
    end

    // Outputs are registered, so they are computed from the post-edge cnt/idx/shadow.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        upper_zero = 1'b1;
        lz_blank   = 1'b0;
        nib        = 4'h0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (shadow_nxt[4*i +: 4] == 4'h0);
            if (IW'(i) == idx_nxt) begin
                nib = shadow_nxt[4*i +: 4];
                if (i != 0) begin
                    lz_blank = lz_en && upper_zero;
                end
            end
        end
        show         = (cnt_nxt >= CNT_BLANK) && !lz_blank;
        an_n_nxt     = show ? ~(DIGITS'(1) << idx_nxt) : '1;
        dig_code_nxt = show ? {1'b0, nib} : CODE_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            shadow       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            an_n         <= '1;
            dig_code     <= CODE_BLANK;
            frame_tick   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            an_n       <= an_n_nxt;
            dig_code   <= dig_code_nxt;
            frame_tick <= boundary;
            if (accept) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end else if (boundary) begin
                pending_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: DIGITS=4, DIV=8, with BLANK=2 (dut_a) and BLANK=0 (dut_b).
module tb_seg_scan_ctrl;

    typedef struct {
        int         cyc;     // -1 means "while rst is high"
        bit         sel;     // 0: dut_a, 1: dut_b
        bit         flags;   // also compare load_ready / frame_tick
        logic [3:0] an;
        logic [4:0] code;
        logic       rdy;
        logic       tick;
        int         phase;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        lz_en = 1'b0;
    logic        ready_a, tick_a, ready_b, tick_b;
    logic [4:0]  code_a, code_b;
    logic [3:0]  an_a, an_b;

    exp_t q[$];
    exp_t keep[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_cyc = 0;
    int   now;
    int   scyc = 0;
    int   phase = 0;

    seg_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK(2)) dut_a (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_a), .lz_en(lz_en), .dig_code(code_a), .an_n(an_a),
        .frame_tick(tick_a)
    );

    seg_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_b), .lz_en(lz_en), .dig_code(code_b), .an_n(an_b),
        .frame_tick(tick_b)
    );

    always #5 clk = ~clk;

    task automatic push(input int cyc, input bit sel, input logic [3:0] an, input logic [4:0] code);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.flags = 1'b0; e.an = an; e.code = code;
        e.rdy = 1'b0; e.tick = 1'b0; e.phase = phase;
        q.push_back(e);
    endtask

    task automatic push_f(input int cyc, input logic [3:0] an, input logic [4:0] code,
                          input logic rdy, input logic tick);
        exp_t e;
        e.cyc = cyc; e.sel = 1'b0; e.flags = 1'b1; e.an = an; e.code = code;
        e.rdy = rdy; e.tick = tick; e.phase = phase;
        q.push_back(e);
    endtask

    // Expected dut_a scan pattern for one whole frame holding value val.
    task automatic expect_frame(input int frame, input logic [15:0] val, input bit lz);
        for (int d = 0; d < 4; d++) begin
            int         base;
            bit         lit;
            logic [3:0] an_on;
            logic [3:0] n;
            base  = (frame * 4 + d) * 8;
            lit   = !(lz && d != 0 && (val >> (4 * d)) == 16'h0);
            an_on = ~(4'b0001 << d);
            n     = val[4*d +: 4];
            push(base,     1'b0, 4'hF, 5'h1F);
            push(base + 1, 1'b0, 4'hF, 5'h1F);
            if (lit) begin
                push(base + 2, 1'b0, an_on, {1'b0, n});
                push(base + 7, 1'b0, an_on, {1'b0, n});
            end else begin
                push(base + 2, 1'b0, 4'hF, 5'h1F);
                push(base + 5, 1'b0, 4'hF, 5'h1F);
                push(base + 7, 1'b0, 4'hF, 5'h1F);
            end
        end
    endtask

    task automatic check_entry(input exp_t e);
        logic [3:0] an;
        logic [4:0] code;
        logic       rdy, tick;
        bit         bad;
        an   = e.sel ? an_b    : an_a;
        code = e.sel ? code_b  : code_a;
        rdy  = e.sel ? ready_b : ready_a;
        tick = e.sel ? tick_b  : tick_a;
        bad  = (an !== e.an) || (code !== e.code);
        if (e.flags) bad = bad || (rdy !== e.rdy) || (tick !== e.tick);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL p%0d_%s_c%0d: got an_n=%b code=%h ready=%b tick=%b, want an_n=%b code=%h ready=%b tick=%b",
                     e.phase, e.sel ? "b" : "a", e.cyc, an, code, rdy, tick, e.an, e.code, e.rdy, e.tick);
        end
    endtask

    // Monitor: on every falling edge compare all entries due this cycle.
    always @(negedge clk) begin
        now = rst ? -1 : mon_cyc;
        keep.delete();
        foreach (q[i]) begin
            if (q[i].cyc == now) begin
                check_entry(q[i]);
            end else if (q[i].cyc < now) begin
                checks++;
                errors++;
                $display("FAIL p%0d_missed_c%0d: entry never compared, now at cycle %0d", q[i].phase, q[i].cyc, now);
            end else begin
                keep.push_back(q[i]);
            end
        end
        q = keep;
        if (rst) mon_cyc = 0;
        else     mon_cyc++;
    end

    task automatic advance();
        @(posedge clk);
        #1;
        scyc++;
    endtask

    task automatic go_to(input int k);
        while (scyc < k) advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        push_f(-1, 4'hF, 5'h1F, 1'b1, 1'b0);
        push(-1, 1'b1, 4'hF, 5'h1F);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        scyc = 0;
        push_f(0, 4'hF, 5'h1F, 1'b1, 1'b0);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && q.size() > 0; i++) advance();
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL p%0d_timeout: %0d entries left, want 0", phase, q.size());
            q.delete();
        end
    endtask

    initial begin
        // Phase 1: reset state and idle scan, both BLANK settings.
        phase = 1;
        do_reset();
        expect_frame(0, 16'h0000, 1'b0);
        push_f(32, 4'hF, 5'h1F, 1'b1, 1'b1);
        push_f(33, 4'hF, 5'h1F, 1'b1, 1'b0);
        push(1,  1'b1, 4'b1110, 5'h00);
        push(7,  1'b1, 4'b1110, 5'h00);
        push(8,  1'b1, 4'b1101, 5'h00);
        push(16, 1'b1, 4'b1011, 5'h00);
        drain(100);

        // Phase 2: frame-aligned load of A3F0.
        phase = 2;
        do_reset();
        expect_frame(0, 16'h0000, 1'b0);
        push_f(5,  4'b1110, 5'h00, 1'b1, 1'b0);
        push_f(6,  4'b1110, 5'h00, 1'b0, 1'b0);
        push_f(31, 4'b0111, 5'h00, 1'b0, 1'b0);
        push_f(32, 4'hF, 5'h1F, 1'b1, 1'b1);
        push_f(33, 4'hF, 5'h1F, 1'b1, 1'b0);
        expect_frame(1, 16'hA3F0, 1'b0);
        push(39, 1'b1, 4'b1110, 5'h00);
        push(40, 1'b1, 4'b1101, 5'h0F);
        go_to(5);
        load_valid = 1'b1;
        load_data  = 16'hA3F0;
        go_to(6);
        load_valid = 1'b0;
        drain(100);

        // Phase 3: leading-zero blanking, first with 0000 then 0040.
        phase = 3;
        lz_en = 1'b1;
        do_reset();
        expect_frame(0, 16'h0000, 1'b1);
        expect_frame(1, 16'h0040, 1'b1);
        go_to(1);
        load_valid = 1'b1;
        load_data  = 16'h0040;
        go_to(2);
        load_valid = 1'b0;
        drain(100);
        lz_en = 1'b0;

        // Phase 4: back-pressure with a held second offer.
        phase = 4;
        do_reset();
        expect_frame(0, 16'h0000, 1'b0);
        push_f(3,  4'b1110, 5'h00, 1'b1, 1'b0);
        push_f(4,  4'b1110, 5'h00, 1'b0, 1'b0);
        push_f(31, 4'b0111, 5'h00, 1'b0, 1'b0);
        push_f(32, 4'hF, 5'h1F, 1'b1, 1'b1);
        push_f(33, 4'hF, 5'h1F, 1'b0, 1'b0);
        expect_frame(1, 16'h1111, 1'b0);
        push_f(64, 4'hF, 5'h1F, 1'b1, 1'b1);
        expect_frame(2, 16'h2222, 1'b0);
        go_to(3);
        load_valid = 1'b1;
        load_data  = 16'h1111;
        go_to(4);
        load_data  = 16'h2222;
        go_to(33);
        load_valid = 1'b0;
        drain(150);

        // Phase 5: asynchronous reset during digit 2 with a pending value.
        phase = 5;
        do_reset();
        push_f(19, 4'b1011, 5'h00, 1'b0, 1'b0);
        go_to(2);
        load_valid = 1'b1;
        load_data  = 16'h5678;
        go_to(3);
        load_valid = 1'b0;
        go_to(20);
        rst = 1'b1;
        push_f(-1, 4'hF, 5'h1F, 1'b1, 1'b0);
        push_f(0, 4'hF, 5'h1F, 1'b1, 1'b0);
        expect_frame(0, 16'h0000, 1'b0);
        push_f(32, 4'hF, 5'h1F, 1'b1, 1'b1);
        expect_frame(1, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        scyc = 0;
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's multi-digit 7-segment display. It holds a DIGITS-nibble display value and feeds one nibble at a time into the shared hex-to-segment decoder, driving the matching active-low digit enable. It provides a dead-time blank between digits, optional leading-zero blanking, and a valid/ready load port whose updates apply only at frame boundaries, so a displayed value never tears. It sits between the counter/state logic that produces values and the single decoder instance.

## Interface
- DIGITS, 4: number of digits scanned; legal range 1..8.
- DIV, 1000: clock cycles per digit slot; must be ≥ BLANK+1.
- BLANK, 8: dead-time cycles at the start of each slot; legal range 0..DIV-1.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load_valid  in  1  new display value offered.
- load_data  in  4*DIGITS  value; nibble i (bits 4i+3:4i) goes to digit i, and digit 0 is the rightmost digit.
- load_ready  out  1  controller can accept a value; equals ~pending_full.
- lz_en  in  1  leading-zero blanking enable; sampled every cycle.
- dig_code  out  5  decoder input: {1'b0, nibble} for display, 5'h1F for blank, which the decoder default renders as all segments off.
- an_n  out  DIGITS  digit enables, active-low, at most one bit low.
- frame_tick  out  1  one-cycle pulse in the first cycle of each new frame.

## Operation
- State:
  - slot counter cnt (0..DIV-1)
  - digit index idx (0..DIGITS-1)
  - shadow register (displayed value)
  - pending register with pending_full flag
- Counter behaviour:
  - cnt increments every cycle and wraps from DIV-1 to 0.
  - On wrap, idx increments and wraps from DIGITS-1 to 0.
  - The frame boundary is the edge where cnt=DIV-1 and idx=DIGITS-1.
- Per-slot phase:
  - BLANK when cnt < BLANK: an_n all ones, dig_code = 5'h1F.
  - SHOW otherwise: an_n has bit idx low, dig_code = {0, shadow nibble idx}.
- Leading-zero rule:
  - Applies when lz_en=1, idx≠0, and shadow nibbles idx..DIGITS-1 are all zero.
  - In that case a SHOW slot behaves as BLANK: an_n all ones, dig_code 5'h1F.
  - Digit 0 is never blanked by this rule.
- Load handshake:
  - A transfer occurs when load_valid & load_ready at an edge.
  - The transfer captures load_data into pending and sets pending_full.
  - At the frame boundary edge with pending_full=1, pending is copied to shadow and pending_full clears.
  - At a frame boundary with pending_full=0, shadow is unchanged.
  - A transfer on the boundary edge itself is possible only when pending_full=0. It fills pending and applies at the next boundary.
  - While load_ready=0, the producer holds load_valid/load_data; nothing is dropped or overwritten.
- frame_tick: a flop set by the frame boundary edge and cleared on the next edge. It is never set by reset release.

## Timing
- Reset values (asserted asynchronously, held while rst=1):
  - cnt=0, idx=0, shadow=0, pending_full=0
  - an_n all ones, dig_code=5'h1F, load_ready=1, frame_tick=0
- an_n and dig_code are flops. They are updated on the same edge as cnt/idx and reflect the new cnt/idx/shadow values.
- Phase sequence after reset release:
  - First edge: cnt=1. BLANK holds for cnt 0..BLANK-1.
  - Digit 0 is shown for cnt BLANK..DIV-1.
- One frame lasts DIGITS*DIV cycles.
- Load latency:
  - load_ready falls in the cycle after the accepting edge.
  - The new value becomes visible at the first SHOW cycle of digit 0 in the frame after the next boundary.
  - load_ready returns to 1 in the same cycle that frame_tick is high.
- A change in lz_en takes effect at the next edge; no frame alignment.
- Reset mid-frame:
  - All outputs return to reset values immediately; pending is discarded.
  - Scanning restarts from digit 0 in BLANK.
- BLANK=0: no dead time; an_n switches directly between adjacent digits on the wrap edge.

## Test plan
DIGITS=4, DIV=8, BLANK=2 throughout; cycle numbers count edges after reset release.
- **Reset, idle scan.** Hold rst=1 → an_n=4'b1111, dig_code=5'h1F, load_ready=1, frame_tick=0. After release: cycles 0-1 blank, cycles 2-7 an_n=4'b1110 with dig_code=5'h00, cycles 10-15 an_n=4'b1101, and so on.
- **Frame-aligned load.** Offer 16'hA3F0 at cycle 5 → accepted; load_ready=0 from cycle 6; frame 0 still shows all zeros. Then:
  - Cycle 32: frame_tick=1 and load_ready=1.
  - Cycles 34-39: an_n=1110, code 5'h00.
  - Cycles 42-47: an_n=1101, code 5'h0F.
  - Digit 2 shows code 5'h03; digit 3 shows 5'h0A.
- **Leading-zero blanking.** lz_en=1, value 16'h0040 → digit 0 shows 5'h00 and digit 1 shows 5'h04; digits 2-3 keep an_n=1111 and 5'h1F for the whole slot. With value 16'h0000, only digit 0 lights.
- **Back-pressure.** Load 16'h1111 at cycle 3, then hold valid with 16'h2222 → ready stays 0 until cycle 32. 16'h2222 is accepted at the end of cycle 32 and shown from cycle 66; frame 1 shows 1111.
- **Async reset mid-operation.** Pending full, rst pulsed between edges during digit 2 SHOW → outputs go to reset values before the next edge, pending is lost, and the display shows 0000 after release.
- **BLANK=0 variant.** an_n goes 1110→1101 on a single edge with no all-ones cycle; dig_code changes on the same edge.
